// File: rtl/rate_meter_pkg.sv
// rate_meter_pkg : shared state encoding and default sizes for the rate meter (rev 1.0).
`default_nettype none

package rate_meter_pkg;

  typedef enum logic [1:0] {
    RM_IDLE    = 2'd0,
    RM_ARM     = 2'd1,
    RM_MEASURE = 2'd2
  } rm_state_e;

  localparam int RM_WIDTH_DEFAULT      = 32;
  localparam int RM_GATE_WIDTH_DEFAULT = 24;

endpackage

`default_nettype wire

// File: rtl/rate_meter_window_timer.sv
// window_timer : loadable gate-window down-counter; a load value of 0 is taken as 1 (rev 1.0).
`default_nettype none

module window_timer
  import rate_meter_pkg::*;
#(
  parameter int GATE_WIDTH = RM_GATE_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [GATE_WIDTH-1:0] value,
  input  logic                  run,
  output logic                  last
);

  logic [GATE_WIDTH-1:0] count;

  // Load wins over run so a window can be reloaded in its final cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= (value == '0) ? GATE_WIDTH'(1) : value;
    end else if (run && (count != '0)) begin
      count <= count - GATE_WIDTH'(1);
    end
  end

  assign last = (count == GATE_WIDTH'(1));

endmodule

`default_nettype wire

// File: rtl/rate_meter.sv
// rate_meter : counts upstream edges over back-to-back gate windows and publishes a rate sample (rev 1.0).
// Define RATE_MAX_EN to build the peak-rate tracker driving rate_max_o.
`default_nettype none

module rate_meter
  import rate_meter_pkg::*;
#(
  parameter int WIDTH      = RM_WIDTH_DEFAULT,
  parameter int GATE_WIDTH = RM_GATE_WIDTH_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [WIDTH-1:0]      count_i,
  input  logic                  enable_i,
  input  logic                  clear_i,
  input  logic [GATE_WIDTH-1:0] gate_cycles_i,
  output logic [WIDTH-1:0]      rate_o,
  output logic                  rate_valid_o,
  output logic [WIDTH-1:0]      rate_max_o,
  output logic                  busy_o
);

  rm_state_e        state;
  rm_state_e        state_next;
  logic [WIDTH-1:0] baseline;
  logic [WIDTH-1:0] delta;
  logic             timer_load;
  logic             timer_run;
  logic             timer_last;
  logic             capture;
  logic             publish;
  logic             busy_next;

  window_timer #(
    .GATE_WIDTH(GATE_WIDTH)
  ) u_timer (
    .clk  (clk_i),
    .rst  (rst_i),
    .load (timer_load),
    .value(gate_cycles_i),
    .run  (timer_run),
    .last (timer_last)
  );

  // Unsigned modulo subtraction absorbs an upstream wrap inside one window.
  assign delta = count_i - baseline;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= RM_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    timer_load = 1'b0;
    timer_run  = 1'b0;
    capture    = 1'b0;
    publish    = 1'b0;
    busy_next  = busy_o;
    case (state)
      RM_IDLE: begin
        if (enable_i) begin
          state_next = RM_ARM;
        end
      end
      RM_ARM: begin
        timer_load = 1'b1;
        capture    = 1'b1;
        busy_next  = 1'b1;
        state_next = RM_MEASURE;
      end
      RM_MEASURE: begin
        timer_run = 1'b1;
        // A clear restarts the window and suppresses any sample due this cycle.
        if (clear_i) begin
          timer_load = 1'b1;
          capture    = 1'b1;
        end else if (timer_last) begin
          publish    = 1'b1;
          timer_load = 1'b1;
          capture    = 1'b1;
        end
        if (!enable_i) begin
          state_next = RM_IDLE;
          busy_next  = 1'b0;
        end
      end
      default: begin
        state_next = RM_IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      baseline     <= '0;
      rate_o       <= '0;
      rate_valid_o <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      rate_valid_o <= publish;
      busy_o       <= busy_next;
      if (capture) begin
        baseline <= count_i;
      end
      if (clear_i) begin
        rate_o <= '0;
      end else if (publish) begin
        rate_o <= delta;
      end
    end
  end

`ifdef RATE_MAX_EN
  logic [WIDTH-1:0] rate_max;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rate_max <= '0;
    end else if (clear_i) begin
      rate_max <= '0;
    end else if (publish && (delta > rate_max)) begin
      rate_max <= delta;
    end
  end

  assign rate_max_o = rate_max;
`else
  assign rate_max_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rate_meter.sv
// tb_rate_meter : directed self-checking bench for rate_meter with a cycle-indexed window model.
`default_nettype none

module tb_rate_meter;

  localparam int W  = 8;
  localparam int GW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic          clr = 1'b0;
  logic [W-1:0]  count = '0;
  logic [W-1:0]  step  = 8'd1;
  logic [GW-1:0] gate  = '0;

  logic [W-1:0]  rate;
  logic          valid;
  logic [W-1:0]  rate_max;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rate_meter #(
    .WIDTH     (W),
    .GATE_WIDTH(GW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .count_i      (count),
    .enable_i     (en),
    .clear_i      (clr),
    .gate_cycles_i(gate),
    .rate_o       (rate),
    .rate_valid_o (valid),
    .rate_max_o   (rate_max),
    .busy_o       (busy)
  );

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Upstream counter: advances by `step` once per cycle, away from both clock edges.
  initial forever begin
    @(negedge clk);
    #2;
    count = count + step;
  end

  // Window model: a window opened at cycle c with length N closes at cycle c+N,
  // and its sample is the count difference between those two cycles.
  initial begin
    int           cyc;
    int           end_cyc;
    bit           armed;
    bit           active;
    logic [W-1:0] base;
    logic [W-1:0] e_rate;
    logic [W-1:0] e_max;
    bit           e_valid;
    bit           e_busy;
    cyc = 0; end_cyc = 0; armed = 0; active = 0;
    base = '0; e_rate = '0; e_max = '0; e_valid = 0; e_busy = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        armed = 0; active = 0; base = '0;
        e_rate = '0; e_max = '0; e_valid = 0; e_busy = 0;
      end else begin
        e_valid = 0;
        if (clr) begin
          e_rate = '0;
          e_max  = '0;
        end
        if (armed) begin
          armed   = 0;
          active  = 1;
          base    = count;
          end_cyc = cyc + ((gate == 0) ? 1 : int'(gate));
          e_busy  = 1;
        end else if (active) begin
          if (clr) begin
            base    = count;
            end_cyc = cyc + ((gate == 0) ? 1 : int'(gate));
          end else if (cyc == end_cyc) begin
            e_rate  = count - base;
            e_valid = 1;
`ifdef RATE_MAX_EN
            if (e_rate > e_max) e_max = e_rate;
`endif
            base    = count;
            end_cyc = cyc + ((gate == 0) ? 1 : int'(gate));
          end
          if (!en) begin
            active = 0;
            e_busy = 0;
          end
        end else if (en) begin
          armed = 1;
        end
      end
      cyc++;
      #1;
      check("model rate", int'(rate), int'(e_rate));
      check("model valid", int'(valid), int'(e_valid));
      check("model busy", int'(busy), int'(e_busy));
      check("model max", int'(rate_max), int'(e_max));
    end
  end

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (!valid && (n < budget));
    if (!valid) check("wait_valid timeout", 0, 1);
  endtask

  task automatic check_max(input string name, input int exp_en);
`ifdef RATE_MAX_EN
    check(name, int'(rate_max), exp_en);
`else
    check(name, int'(rate_max), 0);
`endif
  endtask

  initial begin
    int n;
    // Reset state
    repeat (3) at_neg();
    check("reset rate", int'(rate), 0);
    check("reset valid", int'(valid), 0);
    check("reset busy", int'(busy), 0);
    rst = 1'b0;

    // 1: +1 per cycle, 100-cycle gate
    at_neg();
    step = 8'd1; gate = 12'd100; en = 1'b1;
    @(posedge clk);
    wait_valid(300, n);
    check("t1 first latency", n, 101);
    check("t1 rate", int'(rate), 100);
    wait_valid(300, n);
    check("t1 period", n, 100);
    check("t1 rate2", int'(rate), 100);

    // 3: drop enable mid-window, then re-enable
    repeat (49) at_neg();
    en = 1'b0;
    @(posedge clk);
    #2;
    check("t3 busy low", int'(busy), 0);
    check("t3 rate held", int'(rate), 100);
    repeat (5) at_neg();
    en = 1'b1;
    @(posedge clk);
    wait_valid(300, n);
    check("t3 fresh latency", n, 101);
    check("t3 rate", int'(rate), 100);

    // 2: wrap past 255 inside a window
    at_neg();
    en = 1'b0;
    repeat (3) at_neg();
    count = 8'd250; step = 8'd3; gate = 12'd10; en = 1'b1;
    @(posedge clk);
    wait_valid(50, n);
    check("t2 latency", n, 11);
    check("t2 wrap rate", int'(rate), 30);

    // 4: zero gate behaves as one-cycle windows
    at_neg();
    gate = 12'd0; step = 8'd2;
    wait_valid(50, n);
    for (int i = 0; i < 3; i++) begin
      wait_valid(5, n);
      check("t4 period", n, 1);
      check("t4 rate", int'(rate), 2);
    end

    // 5: clear restarts the window; peak tracking over 40, 75, 60
    at_neg();
    gate = 12'd5; step = 8'd8; clr = 1'b1;
    at_neg();
    clr = 1'b0;
    check("t5 clear rate", int'(rate), 0);
    check_max("t5 clear max", 0);
    wait_valid(20, n);
    check("t5 restart latency", n, 5);
    check("t5 rate 40", int'(rate), 40);
    check_max("t5 max 40", 40);
    at_neg();
    step = 8'd15;
    wait_valid(20, n);
    check("t5 rate 75", int'(rate), 75);
    check_max("t5 max 75", 75);
    at_neg();
    step = 8'd12;
    wait_valid(20, n);
    check("t5 rate 60", int'(rate), 60);
    check_max("t5 max held", 75);
    at_neg();
    clr = 1'b1;
    at_neg();
    clr = 1'b0;
    check("t5 clear2 rate", int'(rate), 0);
    check_max("t5 clear2 max", 0);
    wait_valid(20, n);
    check("t5 clear2 latency", n, 5);
    check("t5 clear2 rate", int'(rate), 60);

    // 6: asynchronous reset between edges
    repeat (2) at_neg();
    #2;
    rst = 1'b1;
    #1;
    check("t6 async rate", int'(rate), 0);
    check("t6 async busy", int'(busy), 0);
    check("t6 async valid", int'(valid), 0);
    check("t6 async max", int'(rate_max), 0);
    at_neg();
    rst = 1'b0;
    @(posedge clk);
    #2;
    check("t6 arm busy", int'(busy), 0);
    @(posedge clk);
    #2;
    check("t6 measure busy", int'(busy), 1);
    wait_valid(20, n);
    check("t6 latency", n, 5);
    check("t6 rate", int'(rate), 60);

    at_neg();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule

`default_nettype wire
